// File: rtl/uart_shift_pkg.sv
// Shared constants and FSM state encodings for the shift-register soft UART.
package uart_shift_pkg;
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [0:0] {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: ticks once per CLKS_PER_BIT cycles, or once per half period
// when half is set (used to reach the centre of the start bit).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    localparam int CW = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic half,
    output logic tick
);
    localparam logic [CW-1:0] FULL_T = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_T = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == (half ? HALF_T : FULL_T));

    always_ff @(posedge clk) begin
        if (!rst || clr || tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end
endmodule

// File: rtl/uart_rx_shift.sv
// 8N1 receiver: two-flop synchronizer, centre sampling, frame-error detection and
// a break guard that waits for the line to return high before re-arming.
module uart_rx_shift
    import uart_shift_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 line,
    output logic [DATA_BITS-1:0] data,
    output logic                 done,
    output logic                 frame_err
);
    logic                 sync_reg [2];
    logic                 rx_s;
    rx_state_t            state_reg;
    logic [DATA_BITS-1:0] sr_reg;
    logic [2:0]           bit_cnt_reg;
    logic                 tick;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst) sync_reg[gi] <= 1'b1;
                    else      sync_reg[gi] <= line;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (!rst) sync_reg[gi] <= 1'b1;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rx_s = sync_reg[1];

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_reg == RX_IDLE) || (state_reg == RX_WAIT_HIGH)),
        .half (state_reg == RX_START),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= RX_IDLE;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
            data        <= '0;
            done        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (!rx_s) state_reg <= RX_START;
                end
                RX_START: begin
                    // A line that is high again at mid start bit was only a glitch.
                    if (tick) begin
                        if (!rx_s) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= RX_DATA;
                        end else begin
                            state_reg <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        sr_reg      <= {rx_s, sr_reg[DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) state_reg <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        if (rx_s) begin
                            data      <= sr_reg;
                            done      <= 1'b1;
                            state_reg <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_reg <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) state_reg <= RX_IDLE;
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_shift.sv
// 8N1 transmitter: loads {stop, data, start} into a 10-bit register and shifts it out LSB first.
module uart_tx_shift
    import uart_shift_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data,
    output logic                 line,
    output logic                 busy
);
    tx_state_t             state_reg;
    logic [FRAME_BITS-1:0] sr_reg;
    logic [3:0]            bit_cnt_reg;
    logic                  tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_reg == TX_IDLE),
        .half (1'b0),
        .tick (tick)
    );

    assign busy = (state_reg == TX_SHIFT);
    assign line = (state_reg == TX_SHIFT) ? sr_reg[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= TX_IDLE;
            sr_reg      <= '0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                TX_IDLE: begin
                    if (start) begin
                        sr_reg      <= {1'b1, data, 1'b0};
                        bit_cnt_reg <= '0;
                        state_reg   <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (tick) begin
                        // The tenth period is the stop bit; leave without shifting.
                        if (bit_cnt_reg == 4'(FRAME_BITS - 1)) begin
                            state_reg <= TX_IDLE;
                        end else begin
                            sr_reg      <= {1'b1, sr_reg[FRAME_BITS-1:1]};
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        end
                    end
                end
                default: state_reg <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/soft_uart_shift.sv
// Soft UART wrapper: independent 8N1 transmitter and receiver sharing one clock.
module soft_uart_shift
    import uart_shift_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_line,
    output logic                 tx_busy,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_frame_err
);
    uart_tx_shift #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst   (rst),
        .start (tx_start),
        .data  (tx_data),
        .line  (tx_line),
        .busy  (tx_busy)
    );

    uart_rx_shift #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .line      (rx_line),
        .data      (rx_data),
        .done      (rx_done),
        .frame_err (rx_frame_err)
    );
endmodule

// File: tb/tb_soft_uart_shift.sv
// Directed bench for soft_uart_shift: loopback frames, glitch rejection, frame error, mid-frame reset.
module tb_soft_uart_shift;
    import uart_shift_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_line, tx_busy;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_done, rx_frame_err;
    logic       loop = 1'b1;
    logic       rx_drv = 1'b1;

    assign rx_line = loop ? tx_line : rx_drv;

    always #5 clk = ~clk;

    soft_uart_shift #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_line      (tx_line),
        .tx_busy      (tx_busy),
        .rx_line      (rx_line),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        if (rst) begin
            if (rx_done) begin
                done_cnt++;
                rx_log.push_back(rx_data);
            end
            if (rx_frame_err) err_cnt++;
            if (rx_done && rx_frame_err) both_cnt++;
            if (tx_busy) busy_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_data  = b;
        tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input string tag);
        int k = 0;
        while (tx_busy !== val && k < 400) begin
            cyc(1);
            k++;
        end
        check(tag, tx_busy, val);
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        cyc(CPB);
    endtask

    initial begin
        int d0, e0, b0;
        logic [9:0] fr;

        // 1: reset held
        rst = 1'b0;
        cyc(5);
        check("rst_tx_line", tx_line, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_rx_err", rx_frame_err, 1'b0);
        rst = 1'b1;
        cyc(5);

        // 2: single A5 frame in loopback, bits sampled at each bit centre
        d0 = done_cnt;
        b0 = busy_cnt;
        fr = {1'b1, 8'hA5, 1'b0};
        send_byte(8'hA5);
        check("t2_busy_rise", tx_busy, 1'b1);
        cyc(8);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_bit%0d", i), tx_line, fr[i]);
            cyc(CPB);
        end
        cyc(10);
        check("t2_busy_cycles", busy_cnt - b0, 160);
        check("t2_done_count", done_cnt - d0, 1);
        check("t2_rx_data", rx_data, 8'hA5);
        check("t2_idle_line", tx_line, 1'b1);

        // 3: back-to-back 00, FF, 3C with tx_start held
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        cyc(1);
        tx_data = 8'hFF;
        wait_busy(1'b0, "t3_end0");
        wait_busy(1'b1, "t3_start1");
        tx_data = 8'h3C;
        wait_busy(1'b0, "t3_end1");
        wait_busy(1'b1, "t3_start2");
        tx_start = 1'b0;
        wait_busy(1'b0, "t3_end2");
        cyc(20);
        check("t3_done_count", done_cnt - d0, 3);
        check("t3_byte0", rx_log[d0], 8'h00);
        check("t3_byte1", rx_log[d0+1], 8'hFF);
        check("t3_byte2", rx_log[d0+2], 8'h3C);
        check("t3_no_err", err_cnt - e0, 0);

        // 4: 4-cycle glitch on rx_line
        loop   = 1'b0;
        rx_drv = 1'b1;
        cyc(5);
        d0 = done_cnt;
        e0 = err_cnt;
        rx_drv = 1'b0;
        cyc(4);
        rx_drv = 1'b1;
        cyc(30);
        check("t4_no_done", done_cnt - d0, 0);
        check("t4_no_err", err_cnt - e0, 0);
        check("t4_idle", dut.u_rx.state_reg, RX_IDLE);

        // 5: stop bit low then line held low 40 cycles
        d0 = done_cnt;
        e0 = err_cnt;
        fr = {1'b0, 8'h81, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(fr[i]);
        cyc(40);
        check("t5_err_count", err_cnt - e0, 1);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_rx_data_held", rx_data, 8'h3C);
        check("t5_wait_high", dut.u_rx.state_reg, RX_WAIT_HIGH);
        rx_drv = 1'b1;
        cyc(10);
        check("t5_back_idle", dut.u_rx.state_reg, RX_IDLE);
        check("t5_err_once", err_cnt - e0, 1);

        // 6: reset during bit 4, then send 5A
        loop = 1'b1;
        send_byte(8'hC3);
        cyc(CPB * 4 + 8);
        check("t6_busy_pre", tx_busy, 1'b1);
        rst = 1'b0;
        cyc(1);
        check("t6_line_after_rst", tx_line, 1'b1);
        check("t6_busy_after_rst", tx_busy, 1'b0);
        check("t6_rx_data_rst", rx_data, 8'h00);
        rst = 1'b1;
        cyc(20);
        d0 = done_cnt;
        send_byte(8'h5A);
        cyc(175);
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_rx_data", rx_data, 8'h5A);

        check("never_both_pulses", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
